// File: rtl/control_fsm.sv
// Multi-cycle RV32-subset control FSM: sequences fetch/decode/execute and drives datapath strobes.
// Optional feature: define CONTROL_FSM_JAL_EN to add the JAL state; otherwise opcode 1101111 traps.
module control_fsm #(
  parameter int INSTR_WIDTH   = 32,  // must be at least 32
  parameter int ALUCTRL_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [INSTR_WIDTH-1:0]   instr,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic                     EQ,
  input  logic                     mem_ready,
  output logic                     RegWrite,
  output logic                     ALUsrc,
  output logic                     PCsrc,
  output logic                     PCwrite,
  output logic                     IRwrite,
  output logic                     MemRead,
  output logic                     MemWrite,
  output logic [ALUCTRL_WIDTH-1:0] ALUctrl,
  output logic [1:0]               ImmSrc,
  output logic [1:0]               ResultSrc,
  output logic                     illegal
);

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
`ifdef CONTROL_FSM_JAL_EN
  localparam logic [6:0] OP_JAL    = 7'b1101111;
`endif

  localparam logic [ALUCTRL_WIDTH-1:0] ALU_ADD = '0;
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_SUB = ALUCTRL_WIDTH'(1);

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_I, S_EXEC_R, S_MEMADR, S_MEMRD, S_MEMWR,
    S_ALUWB, S_MEMWB, S_BRANCH, S_TRAP
`ifdef CONTROL_FSM_JAL_EN
    , S_JAL
`endif
  } state_t;

  state_t     state, state_next;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       handshake;
  logic       branch_taken;
  logic       unused_instr;

  // Only opcode, funct3 and funct7[5] steer control; the rest belongs to the datapath.
  assign unused_instr = ^{instr[INSTR_WIDTH-1:31], instr[29:15], instr[11:7]};

  // Gating with rst_n keeps IRwrite/PCwrite low while reset holds the FSM in FETCH.
  assign handshake    = (state == S_FETCH) && instr_valid && rst_n;
  assign branch_taken = ((funct3 == 3'b000) && EQ) || ((funct3 == 3'b001) && !EQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      opcode   <= '0;
      funct3   <= '0;
      funct7_5 <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_next;
      if (handshake) begin
        opcode   <= instr[6:0];
        funct3   <= instr[14:12];
        funct7_5 <= instr[30];
      end
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_next  = state;
    instr_ready = 1'b0;
    RegWrite    = 1'b0;
    ALUsrc      = 1'b0;
    PCsrc       = 1'b0;
    PCwrite     = 1'b0;
    IRwrite     = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    ALUctrl     = ALU_ADD;
    ImmSrc      = IMM_I;
    ResultSrc   = RES_ALU;
    illegal     = 1'b0;

    case (state)
      S_FETCH: begin
        instr_ready = 1'b1;
        if (handshake) begin
          IRwrite    = 1'b1;
          PCwrite    = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_IMM:             state_next = S_EXEC_I;
          OP_REG:             state_next = S_EXEC_R;
          OP_LOAD, OP_STORE:  state_next = S_MEMADR;
          OP_BRANCH:          state_next = S_BRANCH;
`ifdef CONTROL_FSM_JAL_EN
          OP_JAL:             state_next = S_JAL;
`endif
          default:            state_next = S_TRAP;
        endcase
      end
      S_EXEC_I: begin
        ALUsrc     = 1'b1;
        state_next = S_ALUWB;
      end
      S_EXEC_R: begin
        ALUctrl    = (funct3 == 3'b000 && funct7_5) ? ALU_SUB : ALU_ADD;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMADR: begin
        ALUsrc     = 1'b1;
        ImmSrc     = (opcode == OP_STORE) ? IMM_S : IMM_I;
        state_next = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite   = 1'b1;
        ResultSrc  = RES_MEM;
        state_next = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        if (mem_ready) state_next = S_FETCH;
      end
      S_BRANCH: begin
        ImmSrc     = IMM_B;
        ALUctrl    = ALU_SUB;
        PCsrc      = branch_taken;
        PCwrite    = branch_taken;
        state_next = S_FETCH;
      end
`ifdef CONTROL_FSM_JAL_EN
      S_JAL: begin
        ImmSrc     = IMM_J;
        PCsrc      = 1'b1;
        PCwrite    = 1'b1;
        RegWrite   = 1'b1;
        ResultSrc  = RES_PC4;
        state_next = S_FETCH;
      end
`endif
      S_TRAP: begin
        illegal    = 1'b1;
        state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end

endmodule
